// File: rtl/pci_burst_target.sv
// PCI memory target with a local word memory, burst transfers, wait states and disconnect at window end.
// Define PCI_TGT_BYTE_ENABLE_EN to honour active-low CBE byte enables on write data phases.
module pci_burst_target #(
    parameter int unsigned ADDR_BASE   = 0,
    parameter int unsigned MEM_DEPTH   = 16,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clock,
    input  logic        reset,
    inout  wire  [31:0] AD,
    input  logic [3:0]  CBE,
    input  logic        FRAME,
    input  logic        IRDY,
    output logic        DEVSEL,
    output logic        TRDY,
    output logic        STOP,
    output logic        AD_direction
);
    localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [IW-1:0] LAST    = IW'(MEM_DEPTH - 1);
    localparam logic [31:0]   BASE32  = 32'(ADDR_BASE);
    localparam logic [32:0]   LO      = 33'(ADDR_BASE);
    localparam logic [32:0]   HI      = 33'(ADDR_BASE) + 33'(MEM_DEPTH);
    localparam logic [2:0]    WS_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [2:0] {S_IDLE, S_TURN, S_WAIT, S_DATA, S_DISC, S_IGNORE} state_t;

    state_t         state_q;
    logic           devsel_q, trdy_q, stop_q, dir_q, is_write_q;
    logic [IW-1:0]  index_q;
    logic [2:0]     wcnt_q;
    logic [31:0]    ad_q;
    logic [31:0]    mem_q [MEM_DEPTH];

    logic           hit_d, xfer_d, mem_we_d;
    logic [IW-1:0]  idx_dec_d, index_inc_d;
    logic [31:0]    wr_word_d;

    assign AD           = dir_q ? 32'bz : ad_q;
    assign DEVSEL       = devsel_q;
    assign TRDY         = trdy_q;
    assign STOP         = stop_q;
    assign AD_direction = dir_q;

    assign hit_d       = (CBE[3:1] == 3'b011) && ({1'b0, AD} >= LO) && ({1'b0, AD} < HI);
    assign idx_dec_d   = IW'(AD - BASE32);
    assign index_inc_d = index_q + 1'b1;
    assign xfer_d      = !IRDY;
    // Writes land only in DATA on a real transfer; an edge with reset high never commits one.
    assign mem_we_d    = (state_q == S_DATA) && xfer_d && is_write_q && !reset;

`ifdef PCI_TGT_BYTE_ENABLE_EN
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte_en
        assign wr_word_d[8*gi +: 8] = CBE[gi] ? mem_q[index_q][8*gi +: 8] : AD[8*gi +: 8];
    end
`else
    assign wr_word_d = AD;
`endif

    always_ff @(posedge clock) begin
        if (mem_we_d) begin
            mem_q[index_q] <= wr_word_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            devsel_q   <= 1'b1;
            trdy_q     <= 1'b1;
            stop_q     <= 1'b1;
            dir_q      <= 1'b1;
            is_write_q <= 1'b0;
            index_q    <= '0;
            wcnt_q     <= 3'd0;
            ad_q       <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!FRAME) begin
                        if (hit_d) begin
                            index_q    <= idx_dec_d;
                            devsel_q   <= 1'b0;
                            is_write_q <= CBE[0];
                            if (!CBE[0]) begin
                                state_q <= S_TURN;
                            end else if (WAIT_STATES > 0) begin
                                state_q <= S_WAIT;
                                wcnt_q  <= WS_INIT;
                            end else begin
                                state_q <= S_DATA;
                                trdy_q  <= 1'b0;
                                stop_q  <= !(idx_dec_d == LAST);
                            end
                        end else begin
                            state_q <= S_IGNORE;
                        end
                    end
                end
                S_TURN: begin
                    dir_q <= 1'b0;
                    ad_q  <= mem_q[index_q];
                    if (WAIT_STATES > 0) begin
                        state_q <= S_WAIT;
                        wcnt_q  <= WS_INIT;
                    end else begin
                        state_q <= S_DATA;
                        trdy_q  <= 1'b0;
                        stop_q  <= !(index_q == LAST);
                    end
                end
                S_WAIT: begin
                    if (wcnt_q == 3'd0) begin
                        state_q <= S_DATA;
                        trdy_q  <= 1'b0;
                        stop_q  <= !(index_q == LAST);
                    end else begin
                        wcnt_q <= wcnt_q - 3'd1;
                    end
                end
                S_DATA: begin
                    if ((xfer_d && FRAME) || (!xfer_d && FRAME)) begin
                        state_q  <= S_IDLE;
                        devsel_q <= 1'b1;
                        trdy_q   <= 1'b1;
                        stop_q   <= 1'b1;
                        dir_q    <= 1'b1;
                    end else if (xfer_d && (index_q == LAST)) begin
                        // Burst would run past the window: disconnect and never wrap.
                        state_q <= S_DISC;
                        trdy_q  <= 1'b1;
                        stop_q  <= 1'b0;
                        dir_q   <= 1'b1;
                    end else if (xfer_d) begin
                        index_q <= index_inc_d;
                        stop_q  <= !(index_inc_d == LAST);
                        if (!is_write_q) begin
                            ad_q <= mem_q[index_inc_d];
                        end
                    end
                end
                S_DISC: begin
                    if (FRAME) begin
                        state_q  <= S_IDLE;
                        devsel_q <= 1'b1;
                        trdy_q   <= 1'b1;
                        stop_q   <= 1'b1;
                        dir_q    <= 1'b1;
                    end
                end
                S_IGNORE: begin
                    if (FRAME && IRDY) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pci_burst_target.sv
// Self-checking bench: target A (base 0, no wait states) and target B (base 32, two wait states) share CBE/FRAME/IRDY.
module tb_pci_burst_target;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ad_drv = 32'd0;
    logic        drv_en = 1'b0;
    logic [3:0]  cbe = 4'd0;
    logic        frame = 1'b1;
    logic        irdy = 1'b1;
    wire  [31:0] ad_a, ad_b;
    logic        devsel_a, trdy_a, stop_a, dir_a;
    logic        devsel_b, trdy_b, stop_b, dir_b;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_q [$];
    logic [31:0] wdata [16];
    logic [31:0] model_a [16];
    logic [31:0] model_b [16];

    always #5 clk = ~clk;

    assign ad_a = drv_en ? ad_drv : 32'bz;
    assign ad_b = drv_en ? ad_drv : 32'bz;

    pci_burst_target #(.ADDR_BASE(0), .MEM_DEPTH(16), .WAIT_STATES(0)) dut_a (
        .clock(clk), .reset(rst), .AD(ad_a), .CBE(cbe), .FRAME(frame), .IRDY(irdy),
        .DEVSEL(devsel_a), .TRDY(trdy_a), .STOP(stop_a), .AD_direction(dir_a));

    pci_burst_target #(.ADDR_BASE(32), .MEM_DEPTH(16), .WAIT_STATES(2)) dut_b (
        .clock(clk), .reset(rst), .AD(ad_b), .CBE(cbe), .FRAME(frame), .IRDY(irdy),
        .DEVSEL(devsel_b), .TRDY(trdy_b), .STOP(stop_b), .AD_direction(dir_b));

    // {DEVSEL, TRDY, STOP, AD_direction}
    function automatic logic [3:0] outs(input bit sel);
        return sel ? {devsel_b, trdy_b, stop_b, dir_b} : {devsel_a, trdy_a, stop_a, dir_a};
    endfunction

    function automatic logic [31:0] bus_ad(input bit sel);
        return sel ? ad_b : ad_a;
    endfunction

    // One complete transaction; read data is checked against exp_q as each transfer happens.
    task automatic bus_txn(input bit sel, input logic [31:0] addr, input logic [3:0] cmd,
                           input int n, input logic [3:0] be, input int stall_ph, input string name);
        int          ph = 0, k = 0, first_trdy = -1, ws;
        bit          stalled = 0, is_wr;
        logic [3:0]  o;
        logic [31:0] e;
        ws    = sel ? 2 : 0;
        is_wr = (cmd == 4'b0111);
        $display("[TB] txn %s: dut=%0d addr=%0d cmd=%b n=%0d", name, sel, addr, cmd, n);
        @(negedge clk);
        drv_en = 1'b1; ad_drv = addr; cbe = cmd; frame = 1'b0; irdy = 1'b1;
        @(negedge clk);
        o = outs(sel);
        tests++;
        if (o[3] !== 1'b0) begin
            fails++; $display("FAIL %s_devsel: DEVSEL=%b after E0, want 0", name, o[3]);
        end
        drv_en = is_wr; cbe = be;
        while (ph < n) begin
            if (k > 40) begin
                tests++; fails++;
                $display("FAIL %s_timeout: %0d of %0d transfers done, want all", name, ph, n);
                break;
            end
            o = outs(sel);
            if (o[2] === 1'b0 && first_trdy < 0) begin
                first_trdy = k;
                if (!is_wr) begin
                    tests++;
                    if (o[0] !== 1'b0) begin
                        fails++; $display("FAIL %s_dir: AD_direction=%b at first TRDY, want 0", name, o[0]);
                    end
                end
            end
            frame = (ph == n - 1);
            if (is_wr) ad_drv = wdata[ph];
            if (o[2] === 1'b0 && ph == stall_ph && !stalled) begin
                irdy = 1'b1; stalled = 1;
                if (!is_wr) begin
                    tests++;
                    if (bus_ad(sel) !== exp_q[0]) begin
                        fails++; $display("FAIL %s_hold: AD=%h during stall, want %h", name, bus_ad(sel), exp_q[0]);
                    end
                end
            end else begin
                irdy = 1'b0;
                if (o[2] === 1'b0) begin
                    if (!is_wr) begin
                        tests++;
                        if (exp_q.size() == 0) begin
                            fails++; $display("FAIL %s_data: AD=%h, want no data", name, bus_ad(sel));
                        end else begin
                            e = exp_q.pop_front();
                            if (bus_ad(sel) !== e) begin
                                fails++; $display("FAIL %s_data%0d: AD=%h, want %h", name, ph, bus_ad(sel), e);
                            end
                        end
                    end
                    ph++;
                end
            end
            @(negedge clk); k++;
        end
        o = outs(sel);
        tests++;
        if (o !== 4'hF) begin
            fails++; $display("FAIL %s_end: outputs=%b after last transfer, want 1111", name, o);
        end
        tests++;
        if (first_trdy != (is_wr ? ws : ws + 1)) begin
            fails++; $display("FAIL %s_latency: TRDY low after E%0d, want E%0d", name, first_trdy, is_wr ? ws : ws + 1);
        end
        frame = 1'b1; irdy = 1'b1; drv_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests++;
        if ({devsel_a, trdy_a, stop_a, dir_a} !== 4'hF) begin
            fails++; $display("FAIL reset_a: outputs=%b, want 1111", {devsel_a, trdy_a, stop_a, dir_a});
        end
        tests++;
        if ({devsel_b, trdy_b, stop_b, dir_b} !== 4'hF) begin
            fails++; $display("FAIL reset_b: outputs=%b, want 1111", {devsel_b, trdy_b, stop_b, dir_b});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            wdata[i] = 32'hA000_0000 + 32'(i) * 32'h101;
            model_a[i] = wdata[i];
        end
        bus_txn(0, 0, 4'b0111, 16, 4'b0000, -1, "fill");
        for (int i = 0; i < 16; i++) exp_q.push_back(model_a[i]);
        bus_txn(0, 0, 4'b0110, 16, 4'b0000, -1, "fill_rd");
    endtask

    task automatic test_burst();
        for (int i = 0; i < 4; i++) begin
            wdata[i] = 32'(10 + i);
            model_a[2 + i] = wdata[i];
        end
        bus_txn(0, 2, 4'b0111, 4, 4'b0000, -1, "burst_wr");
        for (int i = 0; i < 4; i++) exp_q.push_back(model_a[2 + i]);
        bus_txn(0, 2, 4'b0110, 4, 4'b0000, -1, "burst_rd");
    endtask

    task automatic test_stall();
        for (int i = 0; i < 4; i++) exp_q.push_back(model_a[i]);
        bus_txn(0, 0, 4'b0110, 4, 4'b0000, 2, "stall_rd");
    endtask

    task automatic test_disconnect();
        logic [3:0] o;
        $display("[TB] txn disc: dut=0 addr=14 cmd=0111 n=4");
        @(negedge clk);
        drv_en = 1'b1; ad_drv = 32'd14; cbe = 4'b0111; frame = 1'b0; irdy = 1'b1;
        @(negedge clk);
        tests++;
        if (trdy_a !== 1'b0 || stop_a !== 1'b1) begin
            fails++; $display("FAIL disc_first: TRDY=%b STOP=%b, want 0 1", trdy_a, stop_a);
        end
        ad_drv = 32'hD15C_0014; cbe = 4'b0000; irdy = 1'b0;
        @(negedge clk);
        tests++;
        if (trdy_a !== 1'b0 || stop_a !== 1'b0) begin
            fails++; $display("FAIL disc_last: TRDY=%b STOP=%b, want 0 0", trdy_a, stop_a);
        end
        ad_drv = 32'hD15C_0015;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            o = {devsel_a, trdy_a, stop_a, dir_a};
            tests++;
            if (o !== 4'b0101) begin
                fails++; $display("FAIL disc_state%0d: outputs=%b, want 0101", i, o);
            end
            ad_drv = 32'hBAD0_0000 + 32'(i);
            frame = (i == 1);
        end
        @(negedge clk);
        tests++;
        if ({devsel_a, trdy_a, stop_a, dir_a} !== 4'hF) begin
            fails++; $display("FAIL disc_release: outputs=%b, want 1111", {devsel_a, trdy_a, stop_a, dir_a});
        end
        frame = 1'b1; irdy = 1'b1; drv_en = 1'b0;
        @(negedge clk);
        model_a[14] = 32'hD15C_0014;
        model_a[15] = 32'hD15C_0015;
        exp_q.push_back(model_a[14]);
        exp_q.push_back(model_a[15]);
        bus_txn(0, 14, 4'b0110, 2, 4'b0000, -1, "disc_rd");
        exp_q.push_back(model_a[0]);
        bus_txn(0, 0, 4'b0110, 1, 4'b0000, -1, "disc_nowrap");
    endtask

    task automatic test_ignore(input logic [31:0] addr, input logic [3:0] cmd, input string name);
        logic [3:0] o;
        $display("[TB] txn %s: dut=0 addr=%0d cmd=%b n=2", name, addr, cmd);
        @(negedge clk);
        drv_en = 1'b1; ad_drv = addr; cbe = cmd; frame = 1'b0; irdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            o = {devsel_a, trdy_a, stop_a, dir_a};
            tests++;
            if (o !== 4'hF) begin
                fails++; $display("FAIL %s_cyc%0d: outputs=%b, want 1111", name, i, o);
            end
            ad_drv = 32'h5A5A_0000 + 32'(i); cbe = 4'b0000;
            frame = (i >= 1); irdy = (i >= 2);
        end
        drv_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_byte_enable();
        wdata[0] = 32'h1122_3344;
        bus_txn(0, 4, 4'b0111, 1, 4'b0000, -1, "be_init");
        wdata[0] = 32'hAABB_CCDD;
        bus_txn(0, 4, 4'b0111, 1, 4'b1100, -1, "be_wr");
`ifdef PCI_TGT_BYTE_ENABLE_EN
        model_a[4] = 32'h1122_CCDD;
`else
        model_a[4] = 32'hAABB_CCDD;
`endif
        exp_q.push_back(model_a[4]);
        bus_txn(0, 4, 4'b0110, 1, 4'b0000, -1, "be_rd");
    endtask

    task automatic test_wait_states();
        wdata[0] = 32'h5555_0005;
        model_b[5] = wdata[0];
        bus_txn(1, 37, 4'b0111, 1, 4'b0000, -1, "ws_wr");
        exp_q.push_back(model_b[5]);
        bus_txn(1, 37, 4'b0110, 1, 4'b0000, -1, "ws_rd");
    endtask

    task automatic test_reset_mid();
        $display("[TB] txn reset_mid: dut=0 addr=0 cmd=0110");
        @(negedge clk);
        drv_en = 1'b1; ad_drv = 32'd0; cbe = 4'b0110; frame = 1'b0; irdy = 1'b1;
        @(negedge clk);
        drv_en = 1'b0; cbe = 4'b0000; irdy = 1'b1;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({devsel_a, trdy_a, stop_a, dir_a} !== 4'hF) begin
            fails++; $display("FAIL reset_mid: outputs=%b right after reset, want 1111", {devsel_a, trdy_a, stop_a, dir_a});
        end
        frame = 1'b1; irdy = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_q.push_back(model_a[0]);
        exp_q.push_back(model_a[1]);
        bus_txn(0, 0, 4'b0110, 2, 4'b0000, -1, "after_reset");
    endtask

    initial begin
        test_reset();
        test_fill();
        test_burst();
        test_stall();
        test_disconnect();
        test_ignore(32'd16, 4'b0111, "ign_addr16");
        test_ignore(32'd3, 4'b0010, "ign_cmd0010");
        test_byte_enable();
        test_wait_states();
        test_reset_mid();
        tests++;
        if (exp_q.size() != 0) begin
            fails++; $display("FAIL scoreboard_left: %0d words pending, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
